// File: rtl/freq_gate_controller.sv
// Gate-time sequencer: toggles the frequency counter's trigger every G' cycles,
// captures counter_output after each gate edge and streams 2^k-reading averages.
module freq_gate_controller #(
    parameter int CNT_WIDTH    = 32,
    parameter int LATCH_DELAY  = 2,
    parameter int AVG_LOG2_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [31:0]          cfg_gate_cycles,
    input  logic [3:0]           cfg_avg_log2,
    input  logic [CNT_WIDTH-1:0] counter_output,
    output logic                 trigger,
    output logic [CNT_WIDTH-1:0] M_AXIS_OUT_tdata,
    output logic                 M_AXIS_OUT_tvalid,
    input  logic                 M_AXIS_OUT_tready,
    output logic                 busy,
    output logic                 overrun
);

    localparam int ACC_W = CNT_WIDTH + AVG_LOG2_MAX;
    localparam int CNT_W = AVG_LOG2_MAX + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       AVG_MAX  = 4'(AVG_LOG2_MAX);
    localparam logic [1:0]       DLY_LOAD = 2'(LATCH_DELAY);

    typedef enum logic [1:0] {IDLE, DISCARD, RUN} state_t;

    state_t               state_q, state_d;
    logic [31:0]          gate_q, gate_d;
    logic [3:0]           avg_q, avg_d;
    logic [31:0]          timer_q, timer_d;
    logic                 trig_q, trig_d;
    logic [1:0]           dly_q, dly_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] tdata_q, tdata_d;
    logic                 tvalid_q, tvalid_d;
    logic                 overrun_q, overrun_d;

    logic [31:0]      gate_eff;
    logic [3:0]       avg_eff;
    logic [ACC_W-1:0] acc_sum;
    logic             capture;
    logic             accept;
    logic             last_reading;

    assign gate_eff     = (cfg_gate_cycles < 32'd4) ? 32'd4 : cfg_gate_cycles;
    assign avg_eff      = (cfg_avg_log2 > AVG_MAX) ? AVG_MAX : cfg_avg_log2;
    assign acc_sum      = acc_q + {{AVG_LOG2_MAX{1'b0}}, counter_output};
    assign capture      = (dly_q == 2'd1);
    assign accept       = tvalid_q & M_AXIS_OUT_tready;
    assign last_reading = ((cnt_q + CNT_ONE) == (CNT_ONE << avg_q));

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path
        // through the branches below can leave one unassigned and infer a latch.
        state_d   = state_q;
        gate_d    = gate_q;
        avg_d     = avg_q;
        timer_d   = timer_q;
        trig_d    = trig_q;
        dly_d     = dly_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        overrun_d = overrun_q;

        if (accept) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    gate_d    = gate_eff;
                    avg_d     = avg_eff;
                    timer_d   = gate_eff - 32'd1;
                    dly_d     = 2'd0;
                    acc_d     = '0;
                    cnt_d     = '0;
                    overrun_d = 1'b0;
                    state_d   = DISCARD;
                end
            end
            DISCARD, RUN: begin
                if (stop) begin
                    // Abort drops the partial average and any capture in flight.
                    dly_d   = 2'd0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    if (dly_q != 2'd0) begin
                        dly_d = dly_q - 2'd1;
                    end
                    if (timer_q == 32'd0) begin
                        trig_d  = ~trig_q;
                        timer_d = gate_q - 32'd1;
                        dly_d   = DLY_LOAD;
                    end else begin
                        timer_d = timer_q - 32'd1;
                    end

                    if (capture) begin
                        if (state_q == DISCARD) begin
                            state_d = RUN;
                        end else if (last_reading) begin
                            tdata_d  = CNT_WIDTH'(acc_sum >> avg_q);
                            tvalid_d = 1'b1;
                            if (tvalid_q && !M_AXIS_OUT_tready) begin
                                overrun_d = 1'b1;
                            end
                            acc_d = '0;
                            cnt_d = '0;
                        end else begin
                            acc_d = acc_sum;
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values of the others, independent of statement order.
        if (rst) begin
            state_q   <= IDLE;
            gate_q    <= '0;
            avg_q     <= '0;
            timer_q   <= '0;
            trig_q    <= 1'b0;
            dly_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gate_q    <= gate_d;
            avg_q     <= avg_d;
            timer_q   <= timer_d;
            trig_q    <= trig_d;
            dly_q     <= dly_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            overrun_q <= overrun_d;
        end
    end

    assign trigger           = trig_q;
    assign M_AXIS_OUT_tdata  = tdata_q;
    assign M_AXIS_OUT_tvalid = tvalid_q;
    assign busy              = (state_q != IDLE);
    assign overrun           = overrun_q;

endmodule

// File: tb/tb_freq_gate_controller.sv
// Self-checking bench for freq_gate_controller: a time-based reference model
// (toggles at multiples of G', captures LATCH_DELAY later) is compared every cycle.
module tb_freq_gate_controller;

    localparam int CW   = 32;
    localparam int LD   = 2;
    localparam int AMAX = 8;

    logic          clk = 1'b0;
    logic          rst, start, stop, tready;
    logic [31:0]   cfg_gate;
    logic [3:0]    cfg_avg;
    logic [CW-1:0] co;
    logic          trigger, tvalid, busy, overrun;
    logic [CW-1:0] tdata;

    always #5 clk = ~clk;

    freq_gate_controller #(
        .CNT_WIDTH    (CW),
        .LATCH_DELAY  (LD),
        .AVG_LOG2_MAX (AMAX)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .stop              (stop),
        .cfg_gate_cycles   (cfg_gate),
        .cfg_avg_log2      (cfg_avg),
        .counter_output    (co),
        .trigger           (trigger),
        .M_AXIS_OUT_tdata  (tdata),
        .M_AXIS_OUT_tvalid (tvalid),
        .M_AXIS_OUT_tready (tready),
        .busy              (busy),
        .overrun           (overrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: time since the start edge decides toggles and captures.
    bit              m_run, m_trig, m_tvalid, m_ovr;
    int              m_e, m_g, m_k, m_rd;
    longint unsigned m_sum;
    logic [CW-1:0]   m_tdata;

    // Stimulus controls
    int co_mode   = 0;   // 0 hold, 1 random
    int ready_pct = -1;  // <0: tready driven manually
    bit rand_ctl  = 1'b0;

    task automatic model_edge();
        bit              accept, load;
        longint unsigned res;
        int              j;
        load = 1'b0;
        res  = 0;
        if (rst) begin
            m_run = 0; m_trig = 0; m_tvalid = 0; m_ovr = 0; m_tdata = '0;
            m_e = 0; m_sum = 0; m_rd = 0;
            return;
        end
        accept = m_tvalid && tready;
        if (!m_run) begin
            if (start && !stop) begin
                m_run = 1; m_e = 0;
                m_g   = (cfg_gate < 4) ? 4 : int'(cfg_gate);
                m_k   = (cfg_avg > AMAX) ? AMAX : int'(cfg_avg);
                m_sum = 0; m_rd = 0; m_ovr = 0;
            end
        end else if (stop) begin
            m_run = 0;
        end else begin
            m_e++;
            if (m_e % m_g == 0) m_trig = ~m_trig;
            if (m_e > LD && (m_e - LD) % m_g == 0) begin
                j = (m_e - LD) / m_g;
                if (j >= 2) begin
                    m_sum += longint'(co);
                    m_rd++;
                    if (m_rd == (1 << m_k)) begin
                        res   = m_sum >> m_k;
                        load  = 1'b1;
                        m_sum = 0;
                        m_rd  = 0;
                    end
                end
            end
        end
        if (load) begin
            if (m_tvalid && !tready) m_ovr = 1;
            m_tdata  = res[CW-1:0];
            m_tvalid = 1;
        end else if (accept) begin
            m_tvalid = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("trigger", trigger, m_trig);
        check("tvalid",  tvalid,  m_tvalid);
        check("tdata",   tdata,   m_tdata);
        check("busy",    busy,    m_run);
        check("overrun", overrun, m_ovr);
        start = 1'b0;
        stop  = 1'b0;
        if (co_mode == 1) co = $urandom;
        if (ready_pct >= 0) tready = ($urandom_range(99) < ready_pct);
        if (rand_ctl) begin
            rst      = ($urandom_range(1999) == 0);
            start    = ($urandom_range(149) == 0);
            stop     = ($urandom_range(399) == 0);
            cfg_gate = $urandom_range(12);
            cfg_avg  = ($urandom_range(5) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(2));
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_start(input int g, input int k);
        cfg_gate = g;
        cfg_avg  = 4'(k);
        start    = 1'b1;
        step();
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; tready = 1'b0;
        cfg_gate = '0; cfg_avg = '0; co = '0;
        run(3);
        rst = 1'b0;
        run(2);

        // Constant reading, no averaging, always ready
        co = 1234; tready = 1'b1;
        pulse_start(50, 0);
        run(300);
        pulse_stop();
        run(5);

        // Averaging over 4 with random readings and backpressure
        co_mode = 1; ready_pct = 70;
        pulse_start(10, 2);
        run(400);
        pulse_stop();
        run(5);

        // Held backpressure across several results, then restart clears overrun
        ready_pct = -1; tready = 1'b0;
        pulse_start(6, 0);
        run(40);
        tready = 1'b1;
        run(5);
        pulse_stop();
        run(3);
        pulse_start(6, 0);
        run(20);
        pulse_stop();
        run(3);

        // Abort after two of four readings, then a fresh run
        ready_pct = 100;
        pulse_start(8, 2);
        run(30);
        pulse_stop();
        run(10);
        pulse_start(8, 2);
        run(60);
        pulse_stop();
        run(3);

        // Clamped config, then config changed mid-run
        pulse_start(2, 12);
        run(20);
        cfg_gate = 100; cfg_avg = 4'd1;
        run(2200);
        pulse_stop();
        run(3);

        // Reset mid-run with a pending result; start+stop together in idle
        ready_pct = -1; tready = 1'b0;
        pulse_start(4, 0);
        run(20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        tready = 1'b1;
        start = 1'b1; stop = 1'b1;
        step();
        run(5);

        // Randomized control, config and backpressure
        rand_ctl = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ready_pct = $urandom_range(100);
            run(500);
        end
        rand_ctl = 1'b0;
        run(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
